// File: rtl/cfg_loader_pkg.sv
// Shared constants, state encoding and helpers for the UART-driven configuration RAM loader.
package cfg_loader_pkg;

  localparam logic [7:0] Header = 8'hAA;

  localparam logic [7:0] UnitNs = 8'd1;
  localparam logic [7:0] UnitUs = 8'd2;
  localparam logic [7:0] UnitMs = 8'd3;

  localparam logic [1:0] ErrNone = 2'd0;
  localparam logic [1:0] ErrChan = 2'd1;
  localparam logic [1:0] ErrUnit = 2'd2;
  localparam logic [1:0] ErrCsum = 2'd3;

  localparam int unsigned PayLen     = 7;
  localparam logic [2:0]  LastIdx    = 3'd6;
  localparam logic [2:0]  WrEnd      = 3'd7;
  localparam logic [2:0]  UnitDlyIdx = 3'd1;
  localparam logic [2:0]  UnitDurIdx = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StChan,
    StPayload,
    StCsum,
    StWrite,
    StDone
  } state_e;

  function automatic logic unit_ok(logic [7:0] u);
    return (u >= UnitNs) && (u <= UnitMs);
  endfunction

  // Channel records are laid out downwards from top_base; wraps modulo 256.
  function automatic logic [7:0] chan_base(logic [7:0] ch, logic [7:0] top_base,
                                           logic [7:0] stride);
    return top_base - stride * (ch - 8'd1);
  endfunction

endpackage

// File: rtl/cfg_frame_timer.sv
// Inter-byte timeout counter: expires after TIMEOUT consecutive enabled cycles without clear.
module cfg_frame_timer #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic clk_CFG,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [15:0] cnt_q;
  logic        at_limit;

  assign at_limit = (cnt_q == TIMEOUT - 16'd1);
  assign expired  = enable && !clear && at_limit;

  always_ff @(posedge clk_CFG or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!enable || clear) begin
      cnt_q <= '0;
    end else if (!at_limit) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/cfg_loader.sv
// Receives framed channel records from a UART, verifies them and writes them into the
// configuration RAM only once the checksum has been accepted.
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned NUM_CH   = 16,
  parameter int unsigned STRIDE   = 7,
  parameter int unsigned TOP_BASE = 105,
  parameter logic [15:0] TIMEOUT  = 16'd50000
) (
  input  logic       clk_CFG,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] w_addr,
  output logic [7:0] ram_data,
  output logic       write,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  state_e     state_q;
  logic [2:0] idx_q;
  logic [7:0] pay_q [PayLen];
  logic [7:0] csum_q;
  logic [7:0] base_q;
  logic       unit_bad_q;
  logic       frame_active;
  logic       timeout_hit;

  assign frame_active = (state_q == StChan) || (state_q == StPayload) || (state_q == StCsum);
  assign busy         = (state_q != StIdle);

  cfg_frame_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_frame_timer (
    .clk_CFG(clk_CFG),
    .rst_n  (rst_n),
    .enable (frame_active),
    .clear  (rx_valid),
    .expired(timeout_hit)
  );

  always_ff @(posedge clk_CFG or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      write      <= 1'b1;
      w_addr     <= '0;
      ram_data   <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ErrNone;
      idx_q      <= '0;
      csum_q     <= '0;
      base_q     <= '0;
      unit_bad_q <= 1'b0;
      pay_q      <= '{default: '0};
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rx_valid && rx_data == Header) state_q <= StChan;
        end
        StChan: begin
          if (timeout_hit) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            if (rx_data == 8'd0 || {24'd0, rx_data} > NUM_CH) begin
              err      <= 1'b1;
              err_code <= ErrChan;
              state_q  <= StIdle;
            end else begin
              base_q     <= chan_base(rx_data, 8'(TOP_BASE), 8'(STRIDE));
              csum_q     <= rx_data;
              unit_bad_q <= 1'b0;
              idx_q      <= '0;
              state_q    <= StPayload;
            end
          end
        end
        StPayload: begin
          if (timeout_hit) begin
            idx_q   <= '0;
            state_q <= StIdle;
          end else if (rx_valid) begin
            // Header-valued bytes land here as ordinary payload; no resync mid-frame.
            pay_q[idx_q] <= rx_data;
            csum_q       <= csum_q ^ rx_data;
            if ((idx_q == UnitDlyIdx || idx_q == UnitDurIdx) && !unit_ok(rx_data)) begin
              unit_bad_q <= 1'b1;
            end
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= StCsum;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        StCsum: begin
          if (timeout_hit) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            if (rx_data != csum_q) begin
              err      <= 1'b1;
              err_code <= ErrCsum;
              state_q  <= StIdle;
            end else if (unit_bad_q) begin
              err      <= 1'b1;
              err_code <= ErrUnit;
              state_q  <= StIdle;
            end else begin
              write    <= 1'b0;
              w_addr   <= base_q;
              ram_data <= pay_q[0];
              idx_q    <= 3'd1;
              state_q  <= StWrite;
            end
          end
        end
        StWrite: begin
          // No backpressure: a byte arriving now is lost and reported as an overrun.
          if (rx_valid) begin
            err      <= 1'b1;
            err_code <= ErrCsum;
          end
          if (idx_q == WrEnd) begin
            write   <= 1'b1;
            done    <= 1'b1;
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            write    <= 1'b0;
            w_addr   <= base_q + {5'd0, idx_q};
            ram_data <= pay_q[idx_q];
            idx_q    <= idx_q + 3'd1;
          end
        end
        StDone: begin
          if (rx_valid) begin
            err      <= 1'b1;
            err_code <= ErrCsum;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter NUM_CH, default 16: number of pulse channels addressable in the configuration RAM.
REQ-002 Parameter STRIDE, default 7: RAM bytes per channel record.
REQ-003 Parameter TOP_BASE, default 105: RAM base address of channel 1; channel n base = TOP_BASE - STRIDE*(n-1).
REQ-004 Parameter TIMEOUT, default 16'd50000: maximum clk_CFG cycles allowed between bytes of one frame.
REQ-005 clk_CFG  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 rx_data  in  8  byte from UART receiver.
REQ-008 rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure is available.
REQ-009 w_addr  out  8  configuration RAM write address.
REQ-010 ram_data  out  8  configuration RAM write data.
REQ-011 write  out  1  RAM write enable, active-low (0 = write).
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 done  out  1  one-cycle pulse after a channel record is fully written.
REQ-014 err  out  1  one-cycle pulse on any frame rejection.
REQ-015 err_code  out  2  reason for last err: 1 bad channel, 2 bad unit, 3 bad checksum/overrun; held until next err.

Function
REQ-016 Frame format: 0xAA header, channel byte (1..NUM_CH), 7 payload bytes P0..P6, checksum byte = XOR of channel byte and P0..P6.
REQ-017 Payload order: P0 type_start, P1 delay unit, P2 delay hi, P3 delay lo, P4 duration unit, P5 duration hi, P6 duration lo.
REQ-018 States: IDLE, CHAN, PAYLOAD, CSUM, WRITE, DONE.
REQ-019 IDLE: rx_valid with 0xAA -> CHAN; any other byte is discarded silently.
REQ-020 CHAN: channel 0 or > NUM_CH -> err, err_code=1, IDLE; otherwise latch channel, -> PAYLOAD.
REQ-021 PAYLOAD: bytes are stored in a 7-entry buffer, index 0..6; after P6 -> CSUM.
REQ-022 A unit byte (P1 or P4) outside 1..3 is flagged and rejects the frame at CSUM with err_code=2.
REQ-023 CSUM: checksum mismatch -> err, err_code=3, IDLE; unit flag set -> err_code=2, IDLE; otherwise -> WRITE.
REQ-024 The RAM is never written before the checksum has been verified; a rejected frame leaves the RAM untouched.
REQ-025 WRITE: for 7 consecutive cycles, k=0..6: write=0, w_addr=base+k, ram_data=Pk; the first write occurs in the cycle after the checksum byte is accepted.
REQ-026 DONE: done=1 for one cycle, then IDLE; total latency from checksum byte to done is 8 cycles.
REQ-027 An rx_valid arriving during WRITE or DONE is dropped and raises err, err_code=3; the write sequence in progress completes.
REQ-028 Inter-byte counter: in CHAN, PAYLOAD or CSUM, TIMEOUT cycles without rx_valid -> IDLE with no err and no RAM write.
REQ-029 A header byte 0xAA received mid-frame is treated as data, not as a resynchronisation.
REQ-030 Address arithmetic is 8-bit unsigned; for the defaults channel 16 maps to 0..6 and channel 1 maps to 105..111.
REQ-031 If err and done conditions coincide, both pulse in the same cycle.
REQ-032 Outside WRITE: write=1; w_addr and ram_data hold their last values.

Reset
REQ-033 rst_n low forces immediately: state IDLE, write=1, w_addr=0, ram_data=0, busy=0, done=0, err=0, err_code=0, buffer index 0, timeout counter 0.
REQ-034 Reset asserted during WRITE aborts the sequence; write returns to 1 asynchronously, and partial RAM contents are accepted as-is.

Structure
REQ-035 A shared package holds the header constant 0xAA, the unit codes (1 ns, 2 us, 3 ms), the err_code values and the state encoding.
REQ-036 One sub-module, cfg_frame_timer, implements the resettable inter-byte timeout counter; all other logic is flat.

Verification
REQ-037 Send AA 01 00 01 00 0A 02 00 05 ^chk -> write=0 at addresses 105..111 with data 00 01 00 0A 02 00 05, done pulses 8 cycles after the checksum byte.
REQ-038 Send AA 10 with a valid payload -> writes to addresses 0..6; then send AA 11 -> err, err_code=1, no write.
REQ-039 Send a correct frame with the checksum byte XORed by 0x01 -> err_code=3; write stays 1 throughout.
REQ-040 Send a frame with P4=04 -> err_code=2, no write.
REQ-041 Stop after P2, idle TIMEOUT+1 cycles, then send a full valid frame for channel 2 -> the first partial frame is discarded, the second is written to addresses 98..104.
REQ-042 Assert rst_n low at the third WRITE cycle -> write=1 and state IDLE immediately; a following valid frame completes normally.
